led_flash_multi: RTL and testbench
==================================

Name: led_flash_multi

Overview:
- Parametrised successor to the single-LED flasher.
- Drives N_LEDS independent LED outputs.
- Each channel is runtime-configurable to OFF, ON, BLINK (50% duty, programmable half-period) or PULSE (one-shot flash).
- A shared prescaler produces a millisecond-class tick; a valid/ready config port sits between top-level control logic (buttons/UART decoder) and the board LEDs.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 1000, base tick rate; DIV = CLK_HZ/TICK_HZ clocks per tick; DIV >= 2 required (elaboration error otherwise).
- N_LEDS, 4, number of channels, 1..16.
- PERIOD_W, 12, width of half-period field in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  block can accept config.
- cfg_chan  in  CW  channel index; CW = max(1, $clog2(N_LEDS)).
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PULSE.
- cfg_half_period  in  PERIOD_W  phase length in ticks (BLINK half-period / PULSE width).
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_chan >= N_LEDS.
- led  out  N_LEDS  LED drive, bit i = channel i, registered.
- busy  out  N_LEDS  bit i high while channel i is in an active PULSE.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - led=0, busy=0, cfg_err=0, cfg_ready=0.
  - all modes=OFF, all half_periods=1, all phase counters=0, prescaler=0.
- cfg_ready: registered; 0 in every cycle following a reset edge, 1 from the first edge with rst=0 onward. It never deasserts otherwise.
- Accept occurs when cfg_valid && cfg_ready at a rising edge. cfg_* are don't-care when not accepted.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick is internal, 1 cycle high when the count is DIV-1.
  - Free-running; never reset by config writes.
- Effective half-period hp = max(cfg_half_period, 1); a value of 0 is treated as 1.
- Config accept, valid channel c:
  - Mode and hp are stored, and c's phase counter is cleared.
  - led[c] updates on the same edge as the accept (visible the cycle after cfg_valid is sampled): OFF->0, ON->1, BLINK->1, PULSE->1.
  - busy[c] = 1 iff mode is PULSE.
- Config accept, invalid channel (cfg_chan >= N_LEDS): the write is dropped, no channel changes, and cfg_err=1 for exactly one cycle. Otherwise cfg_err=0.
- BLINK:
  - On each tick, the phase counter increments.
  - When a tick arrives with counter == hp-1, led[c] toggles and the counter clears.
  - Steady-state phase length is exactly hp*DIV clocks.
  - The first phase after a write is between (hp-1)*DIV+1 and hp*DIV clocks, because the prescaler is unaligned to the write.
- PULSE:
  - Uses the same counting.
  - On the terminating tick: led[c]=0, busy[c]=0, mode becomes OFF.
  - A re-write during a pulse restarts it. A write of another mode aborts it (busy drops on the accept edge).
- OFF/ON: the counter is held at 0 and the LED is static.
- Simultaneous events:
  - A config write to c on the same edge as c's toggle/terminate tick: the write wins and the tick is ignored for c.
  - Other channels are unaffected by writes to c. All channels see the same tick.
- Reset mid-operation: all state returns to reset values on that edge, including active pulses and the prescaler phase. No config is retained.
- Counter width is PERIOD_W; no overflow is possible since the counter < hp <= 2^PERIOD_W-1.

Test Plan:
- Bench params: CLK_HZ=1000, TICK_HZ=100 (DIV=10), N_LEDS=4, PERIOD_W=8.
- Reset hold 10 cycles, release -> led=0000, busy=0000, cfg_err=0 throughout; cfg_ready=0 until the first edge with rst=0, then 1.
- Write chan1 BLINK hp=3 -> led[1]=1 the cycle after accept. After the first toggle, led[1] alternates with exactly 30-clock phases for >=6 phases; other bits stay 0.
- Write chan2 PULSE hp=2, then write chan2 PULSE hp=2 again 12 clocks later -> busy[2] and led[2] stay high, then fall together within 11..20 clocks of the second accept; mode returns to OFF (no further activity).
- Write chan0 ON, chan3 BLINK hp=0 -> led[0] constant 1; led[3] toggles every 10 clocks (hp treated as 1).
- Write cfg_chan=5 with N_LEDS=4 (use N_LEDS=5-index test with CW=3 via N_LEDS=6 build variant, chan=7) -> cfg_err is a single-cycle pulse and led/busy are unchanged. Also a write aligned to chan1's toggle tick -> the write's value wins.
- Assert rst for 1 cycle mid-BLINK/PULSE -> next cycle led=0, busy=0, cfg_ready=0. After release, no channel resumes without new writes.

Source files
------------

// File: rtl/led_flash_multi.sv
// led_flash_multi
//   Multi-channel LED flasher. A shared prescaler divides clk down to a
//   tick of TICK_HZ. Each channel runs independently as OFF, ON, BLINK
//   (50% duty, half-period counted in ticks) or PULSE (a single flash
//   that turns itself off).
//
// Ports
//   clk              system clock
//   rst              synchronous active-high reset
//   cfg_valid        config write request
//   cfg_ready        block can accept config (registered)
//   cfg_chan         channel index to configure
//   cfg_mode         0=OFF, 1=ON, 2=BLINK, 3=PULSE
//   cfg_half_period  phase length in ticks (0 is treated as 1)
//   cfg_err          one-cycle pulse: accepted write named a missing channel
//   led              LED drive, bit i = channel i (registered)
//   busy             bit i high while channel i runs a PULSE
//
// Config handshake: a write is accepted on a rising edge of clk where
// cfg_valid and cfg_ready are both high. cfg_ready rises on the first edge
// after reset is released and then stays high, so the producer may hold
// cfg_valid for one cycle per write. cfg_chan/cfg_mode/cfg_half_period are
// only looked at on an accepting edge.
module led_flash_multi #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int N_LEDS   = 4,
    parameter int PERIOD_W = 12,
    localparam int CW      = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_half_period,
    output logic                cfg_err,
    output logic [N_LEDS-1:0]   led,
    output logic [N_LEDS-1:0]   busy
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    generate
        if (DIV < 2) begin : g_div_check
            $error("led_flash_multi: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (N_LEDS < 1 || N_LEDS > 16) begin : g_nleds_check
            $error("led_flash_multi: N_LEDS must be in 1..16");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared prescaler: free running, only reset clears it
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [1:0]          mode_q [N_LEDS];
    logic [1:0]          mode_n [N_LEDS];
    logic [PERIOD_W-1:0] hp_q   [N_LEDS];
    logic [PERIOD_W-1:0] hp_n   [N_LEDS];
    logic [PERIOD_W-1:0] cnt_q  [N_LEDS];
    logic [PERIOD_W-1:0] cnt_n  [N_LEDS];
    logic [N_LEDS-1:0]   led_q, led_n;
    logic [N_LEDS-1:0]   busy_q, busy_n;
    logic                ready_q;
    logic                err_q, err_n;

    logic                accept;
    logic                chan_ok;
    logic [PERIOD_W-1:0] cfg_hp;

    assign accept  = cfg_valid && ready_q;
    assign chan_ok = (32'(cfg_chan) < N_LEDS);
    assign cfg_hp  = (cfg_half_period == '0) ? PERIOD_W'(1) : cfg_half_period;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                mode_q[i] <= MODE_OFF;
                hp_q[i]   <= PERIOD_W'(1);
                cnt_q[i]  <= '0;
            end
            led_q   <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                mode_q[i] <= mode_n[i];
                hp_q[i]   <= hp_n[i];
                cnt_q[i]  <= cnt_n[i];
            end
            led_q   <= led_n;
            busy_q  <= busy_n;
            ready_q <= 1'b1;
            err_q   <= err_n;
        end
    end

    // Next-state logic
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            mode_n[i] = mode_q[i];
            hp_n[i]   = hp_q[i];
            cnt_n[i]  = cnt_q[i];
        end
        led_n  = led_q;
        busy_n = busy_q;
        err_n  = accept && !chan_ok;

        for (int i = 0; i < N_LEDS; i++) begin
            // Phase counting only runs in BLINK and PULSE; OFF/ON keep
            // the counter parked at zero.
            if (tick && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_PULSE)) begin
                if (cnt_q[i] == hp_q[i] - PERIOD_W'(1)) begin
                    cnt_n[i] = '0;
                    if (mode_q[i] == MODE_BLINK) begin
                        led_n[i] = ~led_q[i];
                    end else begin
                        led_n[i]  = 1'b0;
                        busy_n[i] = 1'b0;
                        mode_n[i] = MODE_OFF;
                    end
                end else begin
                    cnt_n[i] = cnt_q[i] + PERIOD_W'(1);
                end
            end

            // A write to this channel overrides whatever the tick did.
            if (accept && chan_ok && (cfg_chan == CW'(i))) begin
                mode_n[i] = cfg_mode;
                hp_n[i]   = cfg_hp;
                cnt_n[i]  = '0;
                led_n[i]  = (cfg_mode != MODE_OFF);
                busy_n[i] = (cfg_mode == MODE_PULSE);
            end
        end
    end

    // Outputs
    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign led       = led_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_led_flash_multi.sv
// Bench for led_flash_multi: randomized and directed config writes,
// compared every cycle against a tick-counting reference model.
module tb_led_flash_multi;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = 10;
    localparam int N       = 4;
    localparam int PW      = 8;
    localparam int N6      = 6;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (N_LEDS=4)
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan  = '0;
    logic [1:0]    cfg_mode  = '0;
    logic [PW-1:0] cfg_hp    = '0;
    logic          cfg_err;
    logic [N-1:0]  led;
    logic [N-1:0]  busy;

    led_flash_multi #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_LEDS(N), .PERIOD_W(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_half_period(cfg_hp),
        .cfg_err(cfg_err), .led(led), .busy(busy)
    );

    // Second build with N_LEDS=6 so out-of-range channels can be named
    logic          cfg_valid6 = 1'b0;
    logic          cfg_ready6;
    logic [2:0]    cfg_chan6  = '0;
    logic [1:0]    cfg_mode6  = '0;
    logic [PW-1:0] cfg_hp6    = '0;
    logic          cfg_err6;
    logic [N6-1:0] led6;
    logic [N6-1:0] busy6;

    led_flash_multi #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_LEDS(N6), .PERIOD_W(PW)
    ) dut6 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid6), .cfg_ready(cfg_ready6),
        .cfg_chan(cfg_chan6), .cfg_mode(cfg_mode6), .cfg_half_period(cfg_hp6),
        .cfg_err(cfg_err6), .led(led6), .busy(busy6)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // ------------------------------------------------------------------
    // Reference model: each channel remembers its mode, effective
    // half-period and the number of ticks seen since its last write.
    // Edge j after reset release carries a tick when j is a multiple of DIV.
    // ------------------------------------------------------------------
    int  m_j;
    bit  m_ready;
    bit  m_err;
    bit  m_acc;
    bit  m_tick;
    int  m_mode [N];
    int  m_hp   [N];
    int  m_k    [N];
    logic [N-1:0] m_led, m_busy;
    logic [9:0]   exp_q [$];

    always @(posedge clk) begin
        if (rst) begin
            m_j = 0;
            m_ready = 1'b0;
            m_err = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_mode[c] = 0; m_hp[c] = 1; m_k[c] = 0;
            end
        end else begin
            m_acc = cfg_valid && m_ready;
            m_j++;
            m_tick = (m_j % DIV == 0);
            for (int c = 0; c < N; c++) begin
                if (m_acc && int'(cfg_chan) == c) begin
                    m_mode[c] = int'(cfg_mode);
                    m_hp[c]   = (cfg_hp == 0) ? 1 : int'(cfg_hp);
                    m_k[c]    = 0;
                end else if (m_tick && m_mode[c] >= 2) begin
                    m_k[c]++;
                    if (m_mode[c] == 3 && m_k[c] >= m_hp[c]) m_mode[c] = 0;
                end
            end
            m_err   = m_acc && (int'(cfg_chan) >= N);
            m_ready = 1'b1;
        end
        for (int c = 0; c < N; c++) begin
            case (m_mode[c])
                0:       m_led[c] = 1'b0;
                2:       m_led[c] = ((m_k[c] / m_hp[c]) % 2 == 0);
                default: m_led[c] = 1'b1;
            endcase
            m_busy[c] = (m_mode[c] == 3);
        end
        exp_q.push_back({m_ready, m_err, m_busy, m_led});
    end

    // Scoreboard: one expected entry per edge, compared half a cycle later
    logic [9:0] e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led",       32'(led),       32'(e[3:0]));
            check("busy",      32'(busy),      32'(e[7:4]));
            check("cfg_err",   32'(cfg_err),   32'(e[8]));
            check("cfg_ready", 32'(cfg_ready), 32'(e[9]));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_cfg(input int chan, input int mode, input int hp);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(chan);
        cfg_mode  = 2'(mode);
        cfg_hp    = PW'(hp);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_chan  = 2'($urandom);
        cfg_mode  = 2'($urandom);
        cfg_hp    = PW'($urandom);
    endtask

    task automatic write_cfg6(input int chan, input int mode, input int hp);
        @(negedge clk);
        cfg_valid6 = 1'b1;
        cfg_chan6  = 3'(chan);
        cfg_mode6  = 2'(mode);
        cfg_hp6    = PW'(hp);
        @(negedge clk);
        cfg_valid6 = 1'b0;
    endtask

    // Counts clocks until led[ch] (or busy[ch]) changes, bounded.
    task automatic wait_change(input bit use_busy, input int ch, output int cycles);
        logic prev;
        prev = use_busy ? busy[ch] : led[ch];
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (((use_busy ? busy[ch] : led[ch]) == prev) && cycles < 300);
        check("wait_bound", 32'(cycles < 300), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int   cyc;
    int   guard;
    logic lv;

    initial begin
        // Reset hold
        rst = 1'b1;
        idle(10);
        check("ready_in_reset", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(cfg_ready), 32'd1);
        check("led_after_release", 32'(led), 32'd0);

        // BLINK hp=3 on channel 1
        write_cfg(1, 2, 3);
        check("blink_start", 32'(led[1]), 32'd1);
        wait_change(1'b0, 1, cyc);
        check("blink_first_phase", 32'(cyc >= 21 && cyc <= 30), 32'd1);
        for (int p = 0; p < 6; p++) begin
            wait_change(1'b0, 1, cyc);
            check("blink_phase30", 32'(cyc), 32'd30);
        end

        // PULSE hp=2 on channel 2, rewritten 12 clocks later
        write_cfg(2, 3, 2);
        check("pulse_busy", 32'(busy[2]), 32'd1);
        idle(10);
        write_cfg(2, 3, 2);
        check("pulse_restart", 32'({led[2], busy[2]}), 32'b11);
        wait_change(1'b1, 2, cyc);
        check("pulse_fall", 32'(cyc >= 11 && cyc <= 20), 32'd1);
        check("pulse_led_with_busy", 32'(led[2]), 32'd0);
        idle(50);

        // ON on channel 0, BLINK hp=0 on channel 3
        write_cfg(0, 1, 7);
        write_cfg(3, 2, 0);
        wait_change(1'b0, 3, cyc);
        check("hp0_first_phase", 32'(cyc >= 1 && cyc <= 10), 32'd1);
        for (int p = 0; p < 4; p++) begin
            wait_change(1'b0, 3, cyc);
            check("hp0_phase10", 32'(cyc), 32'd10);
        end
        check("on_static", 32'(led[0]), 32'd1);

        // Write landing on the same edge as channel 1's toggle
        guard = 0;
        while (!(((m_j + 1) % DIV == 0) && m_mode[1] == 2 &&
                 ((m_k[1] + 1) % m_hp[1] == 0)) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("align_bound", 32'(guard < 200), 32'd1);
        lv = led[1];
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_mode  = lv ? 2'd1 : 2'd0;
        cfg_hp    = PW'(3);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("write_beats_toggle", 32'(led[1]), 32'(lv));
        idle(25);

        // Out-of-range channel on the 6-channel build
        write_cfg6(5, 3, 200);
        check("v6_valid_err", 32'(cfg_err6), 32'd0);
        check("v6_busy5", 32'(busy6), 32'b100000);
        write_cfg6(7, 1, 1);
        check("v6_err_pulse", 32'(cfg_err6), 32'd1);
        check("v6_led_unchanged", 32'(led6), 32'b100000);
        check("v6_busy_unchanged", 32'(busy6), 32'b100000);
        @(negedge clk);
        check("v6_err_one_cycle", 32'(cfg_err6), 32'd0);
        write_cfg6(6, 2, 1);
        check("v6_err_chan6", 32'(cfg_err6), 32'd1);
        check("v6_led_after_chan6", 32'(led6), 32'b100000);

        // Reset in the middle of BLINK and PULSE
        write_cfg(1, 2, 2);
        write_cfg(2, 3, 9);
        idle(15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(cfg_ready), 32'd0);
        check("midrst_busy6", 32'(busy6), 32'd0);
        idle(100);
        check("no_resume", 32'({busy, led}), 32'd0);

        // Randomized writes with occasional resets
        for (int t = 0; t < 300; t++) begin
            idle($urandom_range(0, 40));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            write_cfg($urandom_range(0, N - 1), $urandom_range(0, 3), $urandom_range(0, 4));
        end
        idle(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
